// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch stage: default width, NOP encoding, instruction field positions, PC step.
package fetch_unit_pkg;

  localparam int          XLEN_DEF  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_INC    = 4;

  localparam int OP_LSB = 0;
  localparam int OP_MSB = 6;
  localparam int F3_LSB = 12;
  localparam int F3_MSB = 14;
  localparam int F7_LSB = 25;
  localparam int F7_MSB = 31;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer for the fetch stage: synchronous FIFO with flush; DEPTH must be a power of two.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; count/empty gate every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, response discard after redirects, decoded ID outputs.
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_op,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);
  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam int EW = XLEN + 32;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] target_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [CW:0]     credit_used;
  logic [EW-1:0]   head;
  logic            run_q, full, empty, grant, drop, push, pop;

  assign target_pc   = redirect_pc & ~XLEN'(3);
  assign credit_used = {1'b0, count} + {1'b0, outstanding};

  // run_q keeps imem_req low while reset is asserted.
  assign imem_req  = run_q && !redirect && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = pc_q;
  assign grant     = imem_req && imem_gnt;
  assign drop      = imem_rvalid && (discard != '0);
  assign push      = imem_rvalid && !drop && !redirect && !full;
  assign pop       = id_valid && id_ready && !redirect;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({resp_pc, imem_rdata}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign id_valid  = !empty;
  assign id_instr  = empty ? NOP_INSTR : head[31:0];
  assign id_pc     = empty ? resp_pc : head[EW-1:32];
  assign id_op     = id_instr[OP_MSB:OP_LSB];
  assign id_funct3 = id_instr[F3_MSB:F3_LSB];
  assign id_funct7 = id_instr[F7_MSB:F7_LSB];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q       <= 1'b0;
      pc_q        <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      run_q       <= 1'b1;
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old stream.
        pc_q    <= target_pc;
        resp_pc <= target_pc;
        discard <= outstanding - CW'(imem_rvalid);
      end else begin
        if (grant) pc_q    <= pc_q + XLEN'(PC_INC);
        if (push)  resp_pc <= resp_pc + XLEN'(PC_INC);
        if (drop)  discard <= discard - CW'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Newly condemned work: buffered entries plus in-flight words not already marked for discard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop)      perf_fetched <= perf_fetched + 32'd1;
      if (redirect) perf_flushed <= perf_flushed + 32'(count) + 32'(outstanding) - 32'(discard);
    end
  end
`endif

endmodule
